// File: rtl/word_store_unit.sv
// word_store_unit: stores a 16-bit word as two byte writes, little-endian by default.
// Define WSU_HIGH_FIRST_EN to write the high byte first (big-endian).
module word_store_unit #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [15:0]           WordIn,
  input  logic [ADDR_WIDTH-1:0] AddrIn,
  input  logic                  MemBusy,
  output logic                  Ready,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [7:0]            MemData,
  output logic                  Done
);
  typedef enum logic [1:0] {IDLE, WR_FIRST, WR_SECOND, DONE} state_e;
  state_e state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nxt;
  logic [7:0] first_byte, second_byte;
`ifdef WSU_HIGH_FIRST_EN
  assign first_byte  = word_q[15:8];
  assign second_byte = word_q[7:0];
`else
  assign first_byte  = word_q[7:0];
  assign second_byte = word_q[15:8];
`endif
  assign addr_nxt = addr_q + 1'b1;
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d = WR_FIRST;
        word_d  = WordIn;
        addr_d  = AddrIn;
      end
      WR_FIRST:  state_d = MemBusy ? WR_FIRST : WR_SECOND;
      WR_SECOND: state_d = MemBusy ? WR_SECOND : DONE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
    end
  end
  // Address and data are forced to zero outside the two write states.
  always_comb begin
    Ready    = state_q == IDLE;
    Done     = state_q == DONE;
    MemWrite = (state_q == WR_FIRST) || (state_q == WR_SECOND);
    MemAddr  = state_q == WR_FIRST ? addr_q : state_q == WR_SECOND ? addr_nxt : '0;
    MemData  = state_q == WR_FIRST ? first_byte : state_q == WR_SECOND ? second_byte : 8'h00;
  end
endmodule

// File: tb/tb_word_store_unit.sv
// tb_word_store_unit: directed checks of word_store_unit byte order, stalls, wrap, reset abort.
module tb_word_store_unit;
  logic Clock = 1'b0;
  logic Reset, Start, MemBusy;
  logic [15:0] WordIn;
  logic [7:0] AddrIn;
  logic Ready, MemWrite, Done;
  logic [7:0] MemAddr, MemData;
  int n_vec = 0;
  int n_bad = 0;

  word_store_unit #(.ADDR_WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .WordIn(WordIn), .AddrIn(AddrIn),
    .MemBusy(MemBusy), .Ready(Ready), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .MemData(MemData), .Done(Done)
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] b1(input logic [15:0] w);
`ifdef WSU_HIGH_FIRST_EN
    return w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  function automatic logic [7:0] b2(input logic [15:0] w);
`ifdef WSU_HIGH_FIRST_EN
    return w[7:0];
`else
    return w[15:8];
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    check({tag, ".we"}, {31'd0, MemWrite}, 32'd1);
    check({tag, ".addr"}, {24'd0, MemAddr}, {24'd0, a});
    check({tag, ".data"}, {24'd0, MemData}, {24'd0, d});
    check({tag, ".rdy"}, {31'd0, Ready}, 32'd0);
    check({tag, ".done"}, {31'd0, Done}, 32'd0);
  endtask

  task automatic chk_quiet(input string tag, input logic rdy, input logic dn);
    check({tag, ".we"}, {31'd0, MemWrite}, 32'd0);
    check({tag, ".addr"}, {24'd0, MemAddr}, 32'd0);
    check({tag, ".data"}, {24'd0, MemData}, 32'd0);
    check({tag, ".rdy"}, {31'd0, Ready}, {31'd0, rdy});
    check({tag, ".done"}, {31'd0, Done}, {31'd0, dn});
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; MemBusy = 1'b0; WordIn = 16'h0; AddrIn = 8'h0;
    cyc(); cyc();
    Reset = 1'b0;
    chk_quiet("reset", 1'b1, 1'b0);

    // basic store, input changed after capture
    WordIn = 16'hA55A; AddrIn = 8'h10; Start = 1'b1;
    cyc(); Start = 1'b0; WordIn = 16'h0000; AddrIn = 8'h77;
    chk_write("basic.w1", 8'h10, b1(16'hA55A));
    cyc(); chk_write("basic.w2", 8'h11, b2(16'hA55A));
    cyc(); chk_quiet("basic.done", 1'b0, 1'b1);
    cyc(); chk_quiet("basic.idle", 1'b1, 1'b0);

    // wrap and stall in the second write
    WordIn = 16'h1234; AddrIn = 8'hFF; Start = 1'b1;
    cyc(); Start = 1'b0;
    chk_write("wrap.w1", 8'hFF, b1(16'h1234));
    cyc(); MemBusy = 1'b1;
    chk_write("wrap.w2a", 8'h00, b2(16'h1234));
    cyc(); chk_write("wrap.w2b", 8'h00, b2(16'h1234));
    cyc(); chk_write("wrap.w2c", 8'h00, b2(16'h1234));
    MemBusy = 1'b0;
    cyc(); chk_quiet("wrap.done", 1'b0, 1'b1);
    cyc(); chk_quiet("wrap.idle", 1'b1, 1'b0);

    // stall in the first write
    WordIn = 16'hC3E1; AddrIn = 8'h80; Start = 1'b1;
    cyc(); Start = 1'b0; MemBusy = 1'b1;
    chk_write("stall1.a", 8'h80, b1(16'hC3E1));
    cyc(); MemBusy = 1'b0;
    chk_write("stall1.b", 8'h80, b1(16'hC3E1));
    cyc(); chk_write("stall1.w2", 8'h81, b2(16'hC3E1));
    cyc(); chk_quiet("stall1.done", 1'b0, 1'b1);
    cyc();

    // Start during a store is ignored
    WordIn = 16'h1234; AddrIn = 8'h20; Start = 1'b1;
    cyc(); WordIn = 16'hFFFF; AddrIn = 8'h40;
    chk_write("ign.w1", 8'h20, b1(16'h1234));
    cyc(); Start = 1'b0;
    chk_write("ign.w2", 8'h21, b2(16'h1234));
    cyc(); chk_quiet("ign.done", 1'b0, 1'b1);
    cyc(); chk_quiet("ign.idle", 1'b1, 1'b0);
    cyc(); chk_quiet("ign.noq", 1'b1, 1'b0);

    // reset aborts the store
    WordIn = 16'hBEEF; AddrIn = 8'h30; Start = 1'b1;
    cyc(); Start = 1'b0;
    chk_write("abort.w1", 8'h30, b1(16'hBEEF));
    Reset = 1'b1;
    cyc(); Reset = 1'b0;
    chk_quiet("abort.r", 1'b1, 1'b0);
    cyc(); chk_quiet("abort.r2", 1'b1, 1'b0);
    cyc(); chk_quiet("abort.r3", 1'b1, 1'b0);

    // back-to-back with Start held high
    WordIn = 16'h0001; AddrIn = 8'h50; Start = 1'b1;
    cyc(); WordIn = 16'h0002;
    chk_write("b2b.w1a", 8'h50, b1(16'h0001));
    cyc(); chk_write("b2b.w2a", 8'h51, b2(16'h0001));
    cyc(); chk_quiet("b2b.doneA", 1'b0, 1'b1);
    cyc(); chk_quiet("b2b.idle", 1'b1, 1'b0);
    cyc(); chk_write("b2b.w1b", 8'h50, b1(16'h0002));
    cyc(); chk_write("b2b.w2b", 8'h51, b2(16'h0002));
    cyc(); Start = 1'b0;
    chk_quiet("b2b.doneB", 1'b0, 1'b1);
    cyc(); chk_quiet("b2b.end", 1'b1, 1'b0);
    cyc(); chk_quiet("b2b.stop", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
